// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo read-side logic.
package fifo_pkg;

  // Default data width of the FIFO and of the downstream stream.
  localparam int unsigned FifoDataWidth = 8;

  // Number of entries in the output skid buffer.
  localparam int unsigned SkidDepth = 2;

  // Skid occupancy, 0..SkidDepth. The extra headroom also holds occ + inflight.
  typedef logic [1:0] occ_t;

  // A new read may be issued when the buffer plus the word in flight leaves room,
  // or when a pop this cycle frees a slot.
  function automatic logic rd_credit(input occ_t occ, input logic inflight, input logic pop);
    occ_t used;
    used = occ + occ_t'(inflight);
    return (used < occ_t'(SkidDepth)) || pop;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry circular skid buffer: write pointer, read pointer and occupancy.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FifoDataWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output occ_t                  occ_o
);

  logic [DATA_WIDTH-1:0] r_mem [SkidDepth];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  occ_t                  r_occ;
  occ_t                  w_occ_next;

  // Occupancy bookkeeping; a simultaneous write and pop leaves it unchanged.
  always_comb begin
    w_occ_next = r_occ + occ_t'(wr_i) - occ_t'(pop_i);
  end

  // Storage, pointers and occupancy; flush empties the buffer but keeps stale contents.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (wr_i) begin
        r_mem[r_wr_ptr] <= wr_data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop_i) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_occ <= w_occ_next;
    end
  end

  assign valid_o = (r_occ != '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign occ_o   = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a sync_fifo read port into a valid/ready stream, hiding the FIFO's
// one-cycle read latency behind a 2-entry skid buffer and counting beats.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FifoDataWidth,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o
);

  logic                 r_inflight;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic                 w_pop;
  logic                 w_rd_en;
  logic                 w_capture;
  logic                 w_valid;
  occ_t                 w_occ;

  assign w_pop = w_valid && m_ready_i;

  // Read issue: only to a non-empty FIFO, never during flush or reset, and only with credit.
  always_comb begin
    w_rd_en = 1'b0;
    if (!rst_i && !fifo_empty_i && !flush_i) begin
      w_rd_en = rd_credit(w_occ, r_inflight, w_pop);
    end
  end

  // Returning data lands one edge after the read; flush throws it away.
  assign w_capture = r_inflight && !flush_i;

  // Track the read whose data returns on the next edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
    end
  end

  // Delivered-beat counter; wraps naturally and is not affected by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= r_beat_cnt + CNT_WIDTH'(1);
    end
  end

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_i),
    .wr_i      (w_capture),
    .wr_data_i (fifo_rd_data_i),
    .pop_i     (w_pop),
    .valid_o   (w_valid),
    .data_o    (m_data_o),
    .occ_o     (w_occ)
  );

  assign fifo_rd_en_o = w_rd_en;
  assign m_valid_o    = w_valid;
  assign beat_cnt_o   = r_beat_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO, scoreboard queue, per-cycle vector table.
module tb_fifo_rd_stream;

  localparam int DW      = 8;
  localparam int CW      = 4;
  localparam int CNT_MOD = 1 << CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready = 1'b0;
  logic [CW-1:0] beat_cnt;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_i        (flush),
    .fifo_empty_i   (fifo_empty),
    .fifo_rd_en_o   (fifo_rd_en),
    .fifo_rd_data_i (fifo_rd_data),
    .m_valid_o      (m_valid),
    .m_data_o       (m_data),
    .m_ready_i      (m_ready),
    .beat_cnt_o     (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ready;
    logic          exp_valid;
    logic          exp_rd;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t          tbl [19];
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  int            total = 0;
  int            bad = 0;
  int            exp_beats = 0;
  int            rd_cnt = 0;
  int            consumed = 0;
  int            rd_pulses = 0;
  bit            underflow_seen = 1'b0;
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          s_valid;
  logic          s_rd;
  logic [DW-1:0] s_data;

  function automatic vec_t mk(input logic r, input logic v, input logic rd, input logic [DW-1:0] d);
    vec_t t;
    t.ready = r; t.exp_valid = v; t.exp_rd = rd; t.exp_data = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DW-1:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic clear_model();
    fifo_q.delete();
    exp_q.delete();
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    exp_beats    = 0;
    rd_cnt       = 0;
    consumed     = 0;
    hold_pend    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; m_ready = 1'b0; flush = 1'b0;
    #1;
    check("rst_valid", 32'(m_valid), 0);
    check("rst_rd_en", 32'(fifo_rd_en), 0);
    check("rst_beat", 32'(beat_cnt), 0);
    check("rst_data", 32'(m_data), 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive at negedge, sample/score at negedge+1, then model the FIFO read edge.
  task automatic step(input logic rdy, input logic fl);
    logic          rd;
    logic [DW-1:0] w;
    int            drop;
    @(negedge clk);
    m_ready = rdy;
    flush   = fl;
    #1;
    s_valid = m_valid; s_rd = fifo_rd_en; s_data = m_data;
    if (hold_pend) begin
      check("hold_valid", 32'(m_valid), 1);
      check("hold_data", 32'(m_data), 32'(hold_data));
    end
    check("beat_cnt", 32'(beat_cnt), 32'(exp_beats % CNT_MOD));
    if (m_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_beat", 32'(m_data), 32'hffff_ffff);
      end else begin
        w = exp_q.pop_front();
        check("sb_data", 32'(m_data), 32'(w));
      end
      exp_beats++;
      consumed++;
    end
    hold_pend = m_valid && !rdy && !fl;
    hold_data = m_data;
    if (fl) begin
      drop = rd_cnt - consumed;
      for (int k = 0; k < drop; k++) begin
        if (exp_q.size() != 0) w = exp_q.pop_front();
      end
      consumed += drop;
    end
    rd = fifo_rd_en;
    if (rd) rd_pulses++;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (rd) begin
      if (fifo_q.size() == 0) begin
        underflow_seen = 1'b1;
      end else begin
        fifo_rd_data = fifo_q.pop_front();
        rd_cnt++;
      end
      fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  initial begin
    int first_v;
    int last_v;
    int n_v;
    bit seen_post;

    // Backpressure then release, 8 words 0xA0..0xA7 preloaded.
    tbl[0] = mk(1'b0, 1'b0, 1'b1, 8'h00);
    tbl[1] = mk(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 2; i < 10; i++) tbl[i] = mk(1'b0, 1'b1, 1'b0, 8'hA0);
    tbl[10] = mk(1'b1, 1'b1, 1'b1, 8'hA0);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 8'hA1);
    for (int i = 12; i < 16; i++) tbl[i] = mk(1'b1, 1'b1, 1'b1, 8'(8'hA0 + i - 10));
    tbl[16] = mk(1'b1, 1'b1, 1'b0, 8'hA6);
    tbl[17] = mk(1'b1, 1'b1, 1'b0, 8'hA7);
    tbl[18] = mk(1'b1, 1'b0, 1'b0, 8'h00);

    do_reset();

    // Basic drain and latency.
    push(8'h11); push(8'h22); push(8'h33);
    step(1'b1, 1'b0);
    check("basic_rd_first", 32'(s_rd), 1);
    check("basic_valid_n", 32'(s_valid), 0);
    step(1'b1, 1'b0);
    check("basic_valid_n1", 32'(s_valid), 0);
    step(1'b1, 1'b0);
    check("basic_valid_n2", 32'(s_valid), 1);
    check("basic_data0", 32'(s_data), 32'h11);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("basic_idle", 32'(s_valid), 0);
    check("basic_beats", 32'(beat_cnt), 3);

    // Backpressure table.
    rd_pulses = 0;
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    for (int i = 0; i < 19; i++) begin
      step(tbl[i].ready, 1'b0);
      check($sformatf("bp_valid[%0d]", i), 32'(s_valid), 32'(tbl[i].exp_valid));
      check($sformatf("bp_rd[%0d]", i), 32'(s_rd), 32'(tbl[i].exp_rd));
      if (tbl[i].exp_valid) check($sformatf("bp_data[%0d]", i), 32'(s_data), 32'(tbl[i].exp_data));
      if (i == 9) check("bp_rd_pulses", rd_pulses, 2);
    end

    // Throughput: 16 back-to-back beats.
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    first_v = -1; last_v = -1; n_v = 0;
    for (int i = 0; i < 22; i++) begin
      step(1'b1, 1'b0);
      if (s_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        n_v++;
      end
    end
    check("tp_count", n_v, 16);
    check("tp_no_gaps", last_v - first_v, 15);
    check("tp_fifo_empty", 32'(fifo_empty), 1);
    check("tp_rd_idle", 32'(s_rd), 0);
    check("tp_beats", 32'(beat_cnt), 32'((3 + 8 + 16) % CNT_MOD));

    // Flush while a read is in flight and one word is buffered.
    for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("fl_no_rd", 32'(s_rd), 0);
    step(1'b1, 1'b0);
    check("fl_valid_after", 32'(s_valid), 0);
    seen_post = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      step(1'b1, 1'b0);
      if (s_valid && !seen_post) begin
        seen_post = 1'b1;
        check("fl_first_after", 32'(s_data), 32'h62);
      end
    end
    check("fl_drained", exp_q.size(), 0);

    // Random ready.
    for (int i = 0; i < 50; i++) push(8'($urandom_range(0, 255)));
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) step(1'($urandom_range(0, 1)), 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", 32'(s_valid), 0);
    check("no_underflow", 32'(underflow_seen), 0);

    // Counter wrap with 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i));
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) step(1'b1, 1'b0);
    check("wrap_drained", exp_q.size(), 0);
    check("wrap_beats", 32'(beat_cnt), 1);

    // Asynchronous reset mid-transfer.
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre_rst_valid", 32'(m_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(m_valid), 0);
    check("async_rst_rd", 32'(fifo_rd_en), 0);
    check("async_rst_beat", 32'(beat_cnt), 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0);
    check("post_rst_idle", 32'(s_valid), 0);
    check("post_rst_rd", 32'(s_rd), 0);
    check("no_underflow_end", 32'(underflow_seen), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run cannot hang.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
